truth_table_sweeper: RTL and testbench

- Parametrised hardware successor to the lab's exhaustive-stimulus benches.
- Drives every combination of VARS inputs into a combinational DUT in binary order, holding each for HOLD_CYCLES clocks.
- Samples the DUT output at the end of each hold and compares it against an expected truth-table parameter.
- Reports pass/fail, mismatch count and first failing index; supports single-shot, continuous and abort modes. Sits beside any labN expression module as a self-checking wrapper.

---
 rtl/truth_table_sweeper.sv | 173 +++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Exhaustive-stimulus self-checking wrapper for a combinational
//               VARS-input DUT. Walks every input index in binary order,
//               holds each for HOLD_CYCLES clocks, samples dut_y at the end
//               of the hold and compares it against the EXPECTED truth table.
//               Reports pass, mismatch count and first failing index.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper #(
    parameter int                      VARS        = 4,
    parameter int                      HOLD_CYCLES = 5,
    parameter logic [(2**VARS)-1:0]    EXPECTED    = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            continuous,
    input  logic            abort,
    input  logic            dut_y,
    output logic [VARS-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [VARS:0]   err_count,
    output logic [VARS-1:0] first_fail_idx,
    output logic            first_fail_valid
);

    localparam int              c_HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [c_HW-1:0] c_HOLD_LAST = c_HW'(HOLD_CYCLES - 1);
    localparam logic [VARS-1:0] c_IDX_MAX   = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SWEEP  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [VARS-1:0] r_idx;
    logic [c_HW-1:0] r_hold;
    logic [VARS:0]   r_err_acc;
    logic [VARS-1:0] r_ff_idx_acc;
    logic            r_ff_valid_acc;

    logic            r_pass;
    logic [VARS:0]   r_err_count;
    logic [VARS-1:0] r_ff_idx;
    logic            r_ff_valid;

    logic            w_sample_pt;
    logic            w_last_idx;
    logic            w_mismatch;
    logic            w_first_fail;
    logic [VARS:0]   w_err_next;

    assign w_sample_pt  = (r_hold == c_HOLD_LAST);
    assign w_last_idx   = (r_idx == c_IDX_MAX);
    assign w_mismatch   = (dut_y != EXPECTED[r_idx]);
    assign w_first_fail = w_mismatch && !r_ff_valid_acc;
    assign w_err_next   = r_err_acc + {{VARS{1'b0}}, w_mismatch};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; abort outranks the end-of-sweep transition
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    w_state_next = S_IDLE;
                end else if (w_sample_pt && w_last_idx) begin
                    w_state_next = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_next = continuous ? S_SWEEP : S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Index/hold counters, per-sweep accumulators and latched results.
    // Results are latched on the edge that enters FINISH so they are already
    // valid while done is high; idx returns to 0 whenever the sweep ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx          <= '0;
            r_hold         <= '0;
            r_err_acc      <= '0;
            r_ff_idx_acc   <= '0;
            r_ff_valid_acc <= 1'b0;
            r_pass         <= 1'b0;
            r_err_count    <= '0;
            r_ff_idx       <= '0;
            r_ff_valid     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx  <= '0;
                    r_hold <= '0;
                    if (start) begin
                        r_err_acc      <= '0;
                        r_ff_idx_acc   <= '0;
                        r_ff_valid_acc <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    if (abort) begin
                        r_idx  <= '0;
                        r_hold <= '0;
                    end else if (w_sample_pt) begin
                        r_err_acc <= w_err_next;
                        if (w_first_fail) begin
                            r_ff_idx_acc   <= r_idx;
                            r_ff_valid_acc <= 1'b1;
                        end
                        if (w_last_idx) begin
                            r_err_count <= w_err_next;
                            r_pass      <= (w_err_next == '0);
                            r_ff_idx    <= w_first_fail ? r_idx : r_ff_idx_acc;
                            r_ff_valid  <= r_ff_valid_acc | w_mismatch;
                        end else begin
                            r_idx  <= r_idx + {{(VARS-1){1'b0}}, 1'b1};
                            r_hold <= '0;
                        end
                    end else begin
                        r_hold <= r_hold + c_HW'(1);
                    end
                end
                S_FINISH: begin
                    r_idx          <= '0;
                    r_hold         <= '0;
                    r_err_acc      <= '0;
                    r_ff_idx_acc   <= '0;
                    r_ff_valid_acc <= 1'b0;
                end
                default: begin
                    r_idx  <= '0;
                    r_hold <= '0;
                end
            endcase
        end
    end

    assign stim             = r_idx;
    assign busy             = (r_state == S_SWEEP) || (r_state == S_FINISH);
    assign done             = (r_state == S_FINISH);
    assign pass             = r_pass;
    assign err_count        = r_err_count;
    assign first_fail_idx   = r_ff_idx;
    assign first_fail_valid = r_ff_valid;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_sweeper
// Description : Directed self-checking bench for truth_table_sweeper with
//               VARS=4, HOLD_CYCLES=5. A second instance with an all-ones
//               truth table and a stuck-at-0 DUT exercises the full-width
//               mismatch count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_truth_table_sweeper;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, continuous, abort, dut_y;
    logic [3:0]  stim, first_fail_idx;
    logic        busy, done, pass, first_fail_valid;
    logic [4:0]  err_count;

    logic        start2, dut_y2;
    logic [3:0]  stim2, first_fail_idx2;
    logic        busy2, done2, pass2, first_fail_valid2;
    logic [4:0]  err_count2;

    logic [15:0] truth_tbl;
    logic        flip;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    // Reference combinational DUT with optional injected faults at idx 6 and 13
    assign dut_y  = truth_tbl[stim] ^ (flip && ((stim == 4'd6) || (stim == 4'd13)));
    assign dut_y2 = 1'b0;

    truth_table_sweeper #(.VARS(4), .HOLD_CYCLES(5), .EXPECTED(16'hA5F0)) u_dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .abort(abort),
        .dut_y(dut_y), .stim(stim), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_idx(first_fail_idx),
        .first_fail_valid(first_fail_valid)
    );

    truth_table_sweeper #(.VARS(4), .HOLD_CYCLES(5), .EXPECTED(16'hFFFF)) u_dut_ones (
        .clk(clk), .rst(rst), .start(start2), .continuous(1'b0), .abort(1'b0),
        .dut_y(dut_y2), .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_fail_idx(first_fail_idx2),
        .first_fail_valid(first_fail_valid2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a sweep and follow it cycle by cycle up to one cycle after done
    task automatic do_sweep(input string tag);
        logic [3:0] exp_stim;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j < 80; j++) begin
            exp_stim = 4'(j / 5);
            n_cmp++;
            if (stim !== exp_stim) begin
                n_err++;
                $display("FAIL %s stim j=%0d got %0h want %0h", tag, j, stim, exp_stim);
            end
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL %s busy/done j=%0d got %b/%b want 1/0", tag, j, busy, done);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL %s finish cycle80 busy/done got %b/%b want 1/1", tag, busy, done);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || stim !== 4'd0) begin
            n_err++;
            $display("FAIL %s after_done busy/done/stim got %b/%b/%0h want 0/0/0", tag, busy, done, stim);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; start2 = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid} !== 16'd0) begin
            n_err++;
            $display("FAIL reset outputs got stim=%0h busy=%b done=%b pass=%b err=%0d ffi=%0d ffv=%b want all 0",
                     stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_pass_sweep();
        flip = 1'b0;
        do_sweep("pass_sweep");
        n_cmp++;
        if (pass !== 1'b1 || err_count !== 5'd0 || first_fail_valid !== 1'b0) begin
            n_err++;
            $display("FAIL pass_sweep results got pass=%b err=%0d ffv=%b want 1/0/0", pass, err_count, first_fail_valid);
        end
    endtask

    task automatic test_mismatch();
        flip = 1'b1;
        do_sweep("mismatch");
        flip = 1'b0;
        n_cmp++;
        if (err_count !== 5'd2) begin
            n_err++;
            $display("FAIL mismatch err_count got %0d want 2", err_count);
        end
        n_cmp++;
        if (first_fail_idx !== 4'd6 || first_fail_valid !== 1'b1) begin
            n_err++;
            $display("FAIL mismatch first_fail got %0d/%b want 6/1", first_fail_idx, first_fail_valid);
        end
        n_cmp++;
        if (pass !== 1'b0) begin
            n_err++;
            $display("FAIL mismatch pass got %b want 0", pass);
        end
    endtask

    task automatic test_all_ones();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (79) tick();
        n_cmp++;
        if (done2 !== 1'b0) begin
            n_err++;
            $display("FAIL all_ones early done got %b want 0", done2);
        end
        tick();
        n_cmp++;
        if (done2 !== 1'b1) begin
            n_err++;
            $display("FAIL all_ones done cycle80 got %b want 1", done2);
        end
        tick();
        n_cmp++;
        if (err_count2 !== 5'd16) begin
            n_err++;
            $display("FAIL all_ones err_count got %0d want 16", err_count2);
        end
        n_cmp++;
        if (first_fail_idx2 !== 4'd0 || first_fail_valid2 !== 1'b1 || pass2 !== 1'b0) begin
            n_err++;
            $display("FAIL all_ones ffi/ffv/pass got %0d/%b/%b want 0/1/0", first_fail_idx2, first_fail_valid2, pass2);
        end
    endtask

    task automatic test_abort();
        bit saw_done;
        test_pass_sweep();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (29) tick();
        n_cmp++;
        if (stim !== 4'd5) begin
            n_err++;
            $display("FAIL abort pre stim got %0h want 5", stim);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || stim !== 4'd0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL abort state busy/stim/done got %b/%0h/%b want 0/0/0", busy, stim, done);
        end
        n_cmp++;
        if (pass !== 1'b1 || err_count !== 5'd0) begin
            n_err++;
            $display("FAIL abort retained pass/err got %b/%0d want 1/0", pass, err_count);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 90; k++) begin
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
            tick();
        end
        n_cmp++;
        if (saw_done) begin
            n_err++;
            $display("FAIL abort idle activity got 1 want 0");
        end
        do_sweep("abort_restart");
        n_cmp++;
        if (pass !== 1'b1) begin
            n_err++;
            $display("FAIL abort_restart pass got %b want 1", pass);
        end
    endtask

    task automatic test_continuous();
        logic exp_done;
        continuous = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= 250; j++) begin
            exp_done = (j == 80) || (j == 161) || (j == 242);
            n_cmp++;
            if (done !== exp_done) begin
                n_err++;
                $display("FAIL continuous done j=%0d got %b want %b", j, done, exp_done);
            end
            if (j == 81 || j == 162) begin
                n_cmp++;
                if (stim !== 4'd0 || busy !== 1'b1) begin
                    n_err++;
                    $display("FAIL continuous restart j=%0d stim/busy got %0h/%b want 0/1", j, stim, busy);
                end
            end
            if (j == 86) begin
                n_cmp++;
                if (stim !== 4'd1) begin
                    n_err++;
                    $display("FAIL continuous second sweep stim got %0h want 1", stim);
                end
            end
            if (j == 243) begin
                n_cmp++;
                if (busy !== 1'b0 || stim !== 4'd0) begin
                    n_err++;
                    $display("FAIL continuous stop busy/stim got %b/%0h want 0/0", busy, stim);
                end
            end
            if (j == 200) continuous = 1'b0;
            tick();
        end
        n_cmp++;
        if (pass !== 1'b1 || err_count !== 5'd0) begin
            n_err++;
            $display("FAIL continuous results pass/err got %b/%0d want 1/0", pass, err_count);
        end
    endtask

    task automatic test_rst_mid();
        logic [3:0] exp_stim;
        start = 1'b1;
        tick();
        for (int j = 0; j < 39; j++) begin
            exp_stim = 4'(j / 5);
            n_cmp++;
            if (stim !== exp_stim) begin
                n_err++;
                $display("FAIL rst_mid start_held stim j=%0d got %0h want %0h", j, stim, exp_stim);
            end
            tick();
        end
        n_cmp++;
        if (stim !== 4'd7 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid cycle39 stim/busy got %0h/%b want 7/1", stim, busy);
        end
        rst = 1'b1;
        tick();
        start = 1'b0;
        n_cmp++;
        if ({stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid} !== 16'd0) begin
            n_err++;
            $display("FAIL rst_mid outputs got stim=%0h busy=%b done=%b pass=%b err=%0d ffi=%0d ffv=%b want all 0",
                     stim, busy, done, pass, err_count, first_fail_idx, first_fail_valid);
        end
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid idle busy got %b want 0", busy);
        end
        do_sweep("rst_restart");
        n_cmp++;
        if (pass !== 1'b1 || err_count !== 5'd0) begin
            n_err++;
            $display("FAIL rst_restart pass/err got %b/%0d want 1/0", pass, err_count);
        end
    endtask

    initial begin
        truth_tbl = 16'hA5F0;
        flip      = 1'b0;
        test_reset();
        test_pass_sweep();
        test_mismatch();
        test_all_ones();
        test_abort();
        test_continuous();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
